rnd_vec_gen_ms: RTL and testbench

Parametrised additive lagged-Fibonacci random-vector generator. Adds explicit multi-word seeding, an automatic warm-up run, multiple addressable checkpoint slots, and a multi-step skip-ahead command. Feeds stimulus vectors to the test-pattern datapath. Stalls the consumer via out_valid/busy while internal stepping is in progress.

---
 rtl/rnd_vec_gen_ms_if.sv | 39 +++
 rtl/rnd_vec_gen_ms.sv | 191 +++++++++++++++++++
 tb/tb_rnd_vec_gen_ms.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rnd_vec_gen_ms_if.sv
// ---------------------------------------------------------------------------
// rnd_vec_gen_ms_if
// Command / result bundle of the lagged-Fibonacci vector generator.
//   master : drives seed_valid, seed_data, next, save, restore, skip, slot,
//            skip_cnt; observes out, out_valid, busy, err
//   slave  : the generator itself (mirror directions)
// SLOT_W = max(1, clog2(NUM_SLOTS)); it must agree with the generator's own
// slot index width.
// ---------------------------------------------------------------------------
interface rnd_vec_gen_ms_if #(
  parameter int OUT_SIZE  = 8,
  parameter int NUM_SLOTS = 4,
  parameter int SKIP_W    = 8
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                seed_valid;
  logic [OUT_SIZE-1:0] seed_data;
  logic                next;
  logic                save;
  logic                restore;
  logic                skip;
  logic [SLOT_W-1:0]   slot;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [OUT_SIZE-1:0] out;
  logic                out_valid;
  logic                busy;
  logic                err;

  modport master (
    output seed_valid, seed_data, next, save, restore, skip, slot, skip_cnt,
    input  out, out_valid, busy, err
  );

  modport slave (
    input  seed_valid, seed_data, next, save, restore, skip, slot, skip_cnt,
    output out, out_valid, busy, err
  );
endinterface

// File: rtl/rnd_vec_gen_ms.sv
// ---------------------------------------------------------------------------
// rnd_vec_gen_ms
// Additive lagged-Fibonacci random-vector generator with multi-word seeding,
// automatic warm-up, addressable checkpoint slots and multi-step skip-ahead.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rnd_vec_gen_ms_if.slave
//          seed_valid/seed_data : one seed word per cycle
//          next/save/restore/skip strobes, slot index, skip_cnt
//          out (= newest generator word), out_valid (READY),
//          busy (SEED/WARMUP/SKIP), err (one-cycle illegal-command pulse)
// ---------------------------------------------------------------------------
module rnd_vec_gen_ms #(
  parameter int OUT_SIZE      = 8,
  parameter int LFSR_LENGTH   = 3,
  parameter int LFSR_FEEDBACK = 2,
  parameter int NUM_SLOTS     = 4,
  parameter int WARMUP_STEPS  = 6,
  parameter int SKIP_W        = 8
) (
  input logic            clk,
  input logic            rst,
  rnd_vec_gen_ms_if.slave bus
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SEED_W = $clog2(LFSR_LENGTH + 1);
  localparam int WARM_W = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
  // One down-counter serves both warm-up and skip runs.
  localparam int STEP_W = (SKIP_W > WARM_W) ? SKIP_W : WARM_W;

  typedef enum logic [2:0] {S_EMPTY, S_SEED, S_WARMUP, S_READY, S_SKIP} state_t;
  typedef enum logic [1:0] {OP_HOLD, OP_SEED, OP_STEP, OP_RESTORE} op_t;

  state_t              r_state;
  logic [SEED_W-1:0]   r_seed_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_err;
  logic [OUT_SIZE-1:0] r_gen [LFSR_LENGTH];           // r_gen[0] is newest
  logic [OUT_SIZE-1:0] r_slot_mem [NUM_SLOTS][LFSR_LENGTH];
  logic [NUM_SLOTS-1:0] r_slot_valid;

  state_t              w_state_next;
  op_t                 w_op;
  logic                w_save_en;
  logic                w_err_next;
  logic                w_out_valid_next;
  logic                w_busy_next;
  logic [SEED_W-1:0]   w_seed_cnt_next;
  logic [STEP_W-1:0]   w_step_cnt_next;
  logic                w_any_cmd;
  logic                w_slot_ok;
  logic                w_seed_last;
  logic                w_any_odd;
  logic [OUT_SIZE-1:0] w_sum;
  logic [OUT_SIZE-1:0] w_step_word;
  logic [OUT_SIZE-1:0] w_gen_next [LFSR_LENGTH];

  assign w_any_cmd   = bus.next | bus.save | bus.restore | bus.skip;
  assign w_slot_ok   = ({1'b0, bus.slot} < (SLOT_W + 1)'(NUM_SLOTS));
  // The word arriving now completes the seed when it is the LFSR_LENGTH-th.
  assign w_seed_last = (r_state == S_SEED) ? (r_seed_cnt == SEED_W'(LFSR_LENGTH - 1))
                                           : (LFSR_LENGTH == 1);

  // Step word: lagged sum, LSB forced to 1 when the whole register is even so
  // the sequence never collapses into the all-even subspace.
  always_comb begin
    w_any_odd = 1'b0;
    for (int i = 0; i < LFSR_LENGTH; i++) w_any_odd = w_any_odd | r_gen[i][0];
    w_sum = r_gen[LFSR_LENGTH-1] + r_gen[LFSR_FEEDBACK-1];
  end
  assign w_step_word = w_sum | OUT_SIZE'(!w_any_odd);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_seed_cnt  <= '0;
      r_step_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_seed_cnt  <= w_seed_cnt_next;
      r_step_cnt  <= w_step_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_busy      <= w_busy_next;
      r_err       <= w_err_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    if (bus.seed_valid) begin
      // Seeding preempts everything, including warm-up and skip runs.
      if (!w_seed_last)           w_state_next = S_SEED;
      else if (WARMUP_STEPS == 0) w_state_next = S_READY;
      else                        w_state_next = S_WARMUP;
    end else begin
      case (r_state)
        S_WARMUP, S_SKIP: if (r_step_cnt <= STEP_W'(1)) w_state_next = S_READY;
        S_READY: if (!bus.restore && !bus.save && !bus.next && bus.skip &&
                     (bus.skip_cnt != '0)) w_state_next = S_SKIP;
        default: w_state_next = r_state;
      endcase
    end
  end

  // ---------------- FSM: output / datapath control ----------------
  always_comb begin
    w_op             = OP_HOLD;
    w_save_en        = 1'b0;
    w_err_next       = 1'b0;
    w_seed_cnt_next  = r_seed_cnt;
    w_step_cnt_next  = r_step_cnt;
    w_out_valid_next = (w_state_next == S_READY);
    w_busy_next      = (w_state_next == S_SEED) || (w_state_next == S_WARMUP) ||
                       (w_state_next == S_SKIP);
    if (bus.seed_valid) begin
      w_op            = OP_SEED;
      w_err_next      = w_any_cmd;
      w_seed_cnt_next = (r_state == S_SEED) ? r_seed_cnt + SEED_W'(1) : SEED_W'(1);
      w_step_cnt_next = STEP_W'(WARMUP_STEPS);
    end else begin
      case (r_state)
        S_WARMUP, S_SKIP: begin
          w_op            = OP_STEP;
          w_step_cnt_next = r_step_cnt - STEP_W'(1);
          w_err_next      = w_any_cmd;
        end
        S_READY: begin
          if (bus.restore) begin
            if (w_slot_ok && r_slot_valid[bus.slot]) w_op = OP_RESTORE;
            else                                     w_err_next = 1'b1;
          end else if (bus.save) begin
            if (w_slot_ok) w_save_en  = 1'b1;
            else           w_err_next = 1'b1;
          end else if (bus.next) begin
            w_op = OP_STEP;
          end else if (bus.skip) begin
            w_step_cnt_next = STEP_W'(bus.skip_cnt);
          end
        end
        default: w_err_next = w_any_cmd;   // EMPTY or SEED without a word
      endcase
    end
  end

  // ---------------- generator register ----------------
  genvar gi;
  generate
    for (gi = 0; gi < LFSR_LENGTH; gi++) begin : g_gen_next
      logic [OUT_SIZE-1:0] w_shift_in;
      if (gi == 0) begin : g_head
        assign w_shift_in = (w_op == OP_SEED) ? bus.seed_data : w_step_word;
      end else begin : g_tail
        assign w_shift_in = r_gen[gi-1];
      end
      assign w_gen_next[gi] = (w_op == OP_RESTORE) ? r_slot_mem[bus.slot][gi] : w_shift_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LFSR_LENGTH; i++) r_gen[i] <= '0;
    end else if (w_op != OP_HOLD) begin
      for (int i = 0; i < LFSR_LENGTH; i++) r_gen[i] <= w_gen_next[i];
    end
  end

  // Checkpoint slots are cleared by reset, so they live in flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= '0;
      for (int s = 0; s < NUM_SLOTS; s++)
        for (int i = 0; i < LFSR_LENGTH; i++) r_slot_mem[s][i] <= '0;
    end else if (w_save_en) begin
      r_slot_valid[bus.slot] <= 1'b1;
      for (int i = 0; i < LFSR_LENGTH; i++) r_slot_mem[bus.slot][i] <= r_gen[i];
    end
  end

  assign bus.out       = r_gen[0];
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_rnd_vec_gen_ms.sv
module tb_rnd_vec_gen_ms;
  localparam int OUT_SIZE      = 8;
  localparam int LFSR_LENGTH   = 3;
  localparam int LFSR_FEEDBACK = 2;
  localparam int NUM_SLOTS     = 4;
  localparam int WARMUP_STEPS  = 6;
  localparam int SKIP_W        = 8;
  localparam int SLOT_W        = 2;

  logic clk;
  logic rst;

  rnd_vec_gen_ms_if #(.OUT_SIZE(OUT_SIZE), .NUM_SLOTS(NUM_SLOTS), .SKIP_W(SKIP_W)) bus_if ();

  rnd_vec_gen_ms #(
    .OUT_SIZE(OUT_SIZE), .LFSR_LENGTH(LFSR_LENGTH), .LFSR_FEEDBACK(LFSR_FEEDBACK),
    .NUM_SLOTS(NUM_SLOTS), .WARMUP_STEPS(WARMUP_STEPS), .SKIP_W(SKIP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string               name;
    logic [OUT_SIZE-1:0] out;
    bit                  valid;
    bit                  err;
    bit                  busy;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: sliding window of the last LFSR_LENGTH sequence values,
  // oldest first; the newest (back) is what the generator presents on out.
  logic [OUT_SIZE-1:0] win[$];
  logic [OUT_SIZE-1:0] m_slot [NUM_SLOTS][LFSR_LENGTH];
  bit                  m_slot_ok [NUM_SLOTS];
  bit                  m_ready;

  function automatic void m_push(logic [OUT_SIZE-1:0] w);
    win.push_back(w);
    void'(win.pop_front());
  endfunction

  // x[n] = x[n-L] + x[n-F] mod 2^N, made odd if the window holds no odd value
  function automatic void m_step();
    logic [OUT_SIZE-1:0] nxt;
    bit odd;
    odd = 1'b0;
    foreach (win[i]) odd = odd | win[i][0];
    nxt = win[win.size() - LFSR_LENGTH] + win[win.size() - LFSR_FEEDBACK];
    if (!odd) nxt = nxt | OUT_SIZE'(1);
    m_push(nxt);
  endfunction

  function automatic void m_reset();
    win = {};
    for (int i = 0; i < LFSR_LENGTH; i++) win.push_back('0);
    for (int s = 0; s < NUM_SLOTS; s++) m_slot_ok[s] = 1'b0;
    m_ready = 1'b0;
  endfunction

  task automatic expect_obs(string nm, bit v, bit e, bit b);
    exp_t x;
    x.name = nm; x.out = win[win.size()-1]; x.valid = v; x.err = e; x.busy = b;
    exp_q.push_back(x);
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end else begin
      $display("[%0t] %s: %0d", $time, nm, got);
    end
  endtask

  task automatic clear_strobes();
    bus_if.seed_valid = 1'b0;
    bus_if.next       = 1'b0;
    bus_if.save       = 1'b0;
    bus_if.restore    = 1'b0;
    bus_if.skip       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic idle(int n);
    repeat (n) begin
      if (m_ready) expect_obs("idle", 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  // Back-to-back seeding followed by the automatic warm-up run.
  task automatic seed_seq(logic [OUT_SIZE-1:0] a, logic [OUT_SIZE-1:0] b,
                          logic [OUT_SIZE-1:0] c, bit with_cmd);
    logic [OUT_SIZE-1:0] w [LFSR_LENGTH];
    bit last;
    w[0] = a; w[1] = b; w[2] = c;
    m_ready = 1'b0;
    for (int i = 0; i < LFSR_LENGTH; i++) begin
      bus_if.seed_valid = 1'b1;
      bus_if.seed_data  = w[i];
      m_push(w[i]);
      last = (i == LFSR_LENGTH - 1);
      if (with_cmd && i == 0) begin
        bus_if.next = 1'b1;
        expect_obs("seed_cmd_err", last && WARMUP_STEPS == 0, 1'b1, !(last && WARMUP_STEPS == 0));
      end else if (last && WARMUP_STEPS == 0) begin
        expect_obs("seed_done", 1'b1, 1'b0, 1'b0);
      end
      tick();
    end
    for (int k = 1; k <= WARMUP_STEPS; k++) begin
      m_step();
      if (k == WARMUP_STEPS) expect_obs("warmup_done", 1'b1, 1'b0, 1'b0);
      tick();
    end
    m_ready = 1'b1;
  endtask

  // One command cycle; inj=1 strobes next during the 2nd busy cycle of a skip,
  // inj=2 aborts the skip with a fresh seed at that point.
  task automatic cmd(bit rs, bit sv, bit nx, bit sk, int s, int k, int inj);
    bus_if.restore  = rs;
    bus_if.save     = sv;
    bus_if.next     = nx;
    bus_if.skip     = sk;
    bus_if.slot     = SLOT_W'(s);
    bus_if.skip_cnt = SKIP_W'(k);
    if (!m_ready) begin
      if (rs | sv | nx | sk) expect_obs("empty_cmd_err", 1'b0, 1'b1, 1'b0);
      tick();
    end else if (rs) begin
      if (m_slot_ok[s]) for (int i = 0; i < LFSR_LENGTH; i++) win[i] = m_slot[s][i];
      expect_obs(m_slot_ok[s] ? "restore" : "restore_err", 1'b1, !m_slot_ok[s], 1'b0);
      tick();
    end else if (sv) begin
      for (int i = 0; i < LFSR_LENGTH; i++) m_slot[s][i] = win[i];
      m_slot_ok[s] = 1'b1;
      expect_obs("save", 1'b1, 1'b0, 1'b0);
      tick();
    end else if (nx) begin
      m_step();
      expect_obs("next", 1'b1, 1'b0, 1'b0);
      tick();
    end else if (sk && k > 0) begin
      m_ready = 1'b0;
      tick();
      for (int j = 1; j <= k; j++) begin
        if (j == 2 && inj == 2) begin
          seed_seq(OUT_SIZE'($urandom_range(0, 255)), OUT_SIZE'($urandom_range(0, 255)),
                   OUT_SIZE'($urandom_range(0, 255)), 1'b0);
          return;
        end
        if (j == 2 && inj == 1) bus_if.next = 1'b1;
        m_step();
        if (j == k) expect_obs("skip_done", 1'b1, (j == 2 && inj == 1), 1'b0);
        else if (j == 2 && inj == 1) expect_obs("busy_cmd_err", 1'b0, 1'b1, 1'b1);
        tick();
      end
      m_ready = 1'b1;
    end else begin
      expect_obs(sk ? "skip_zero" : "idle", 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  // Monitor: every cycle the DUT presents a vector or an error pulse is
  // matched against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus_if.out_valid || bus_if.err)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got valid=%0b out=%0d err=%0b, expected no output",
                   bus_if.out_valid, bus_if.out, bus_if.err);
        end else begin
          e = exp_q.pop_front();
          if (bus_if.out_valid !== e.valid || bus_if.err !== e.err || bus_if.busy !== e.busy ||
              (e.valid && bus_if.out !== e.out)) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b out=%0d err=%0b busy=%0b, expected valid=%0b out=%0d err=%0b busy=%0b",
                     e.name, bus_if.out_valid, bus_if.out, bus_if.err, bus_if.busy,
                     e.valid, e.out, e.err, e.busy);
          end else begin
            $display("[%0t] %s: out=%0d valid=%0b err=%0b busy=%0b",
                     $time, e.name, bus_if.out, bus_if.out_valid, bus_if.err, bus_if.busy);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    rst = 1'b1;
    clear_strobes();
    bus_if.seed_data = '0;
    bus_if.slot      = '0;
    bus_if.skip_cnt  = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(bus_if.out), 32'd0);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_err", 32'(bus_if.err), 32'd0);
    rst = 1'b0;

    // command before any seed
    cmd(1, 0, 0, 0, 1, 0, 0);
    // seed 1,2,3 then a run of next strobes
    seed_seq(8'd1, 8'd2, 8'd3, 1'b0);
    repeat (7) cmd(0, 0, 1, 0, 0, 0, 0);
    // all-even seed exercises the forced-odd LSB
    seed_seq(8'd2, 8'd4, 8'd6, 1'b0);
    repeat (2) cmd(0, 0, 1, 0, 0, 0, 0);
    // checkpoint save / restore, restore of a never-saved slot
    seed_seq(8'd1, 8'd2, 8'd3, 1'b0);
    cmd(0, 1, 0, 0, 1, 0, 0);
    repeat (3) cmd(0, 0, 1, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 1, 0, 0);
    repeat (2) cmd(0, 0, 1, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 2, 0, 0);
    // skip-ahead with a next strobe while busy
    seed_seq(8'd1, 8'd2, 8'd3, 1'b0);
    cmd(0, 0, 0, 1, 0, 4, 1);
    // command priority and zero-length skip
    cmd(1, 1, 1, 1, 1, 3, 0);
    cmd(0, 1, 1, 1, 3, 3, 0);
    cmd(0, 0, 1, 1, 0, 3, 0);
    cmd(0, 0, 0, 1, 0, 0, 0);
    // seed together with a command, and seed aborting a skip
    seed_seq(8'd5, 8'd9, 8'd17, 1'b1);
    cmd(0, 0, 0, 1, 0, 4, 2);
    idle(2);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      cmd(0, 0, 1, 0, 0, 0, 0);
      else if (r < 45) cmd(0, 1, 0, 0, $urandom_range(0, NUM_SLOTS - 1), 0, 0);
      else if (r < 60) cmd(1, 0, 0, 0, $urandom_range(0, NUM_SLOTS - 1), 0, 0);
      else if (r < 72) cmd(0, 0, 0, 1, 0, $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? 1 : 0);
      else if (r < 80) cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), $urandom_range(0, NUM_SLOTS - 1),
                           $urandom_range(0, 5), 0);
      else if (r < 88) idle($urandom_range(1, 3));
      else if (r < 94) seed_seq(OUT_SIZE'($urandom_range(0, 255)), OUT_SIZE'($urandom_range(0, 255)),
                                OUT_SIZE'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      else             cmd(0, 0, 0, 1, 0, 4, 2);
    end

    // asynchronous reset in the middle of a skip run
    cmd(0, 1, 0, 0, 1, 0, 0);
    bus_if.skip     = 1'b1;
    bus_if.skip_cnt = SKIP_W'(4);
    m_ready = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midskip_rst_out", 32'(bus_if.out), 32'd0);
    check("midskip_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midskip_rst_busy", 32'(bus_if.busy), 32'd0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cmd(1, 0, 0, 0, 1, 0, 0);
    seed_seq(8'd1, 8'd2, 8'd3, 1'b0);
    cmd(1, 0, 0, 0, 1, 0, 0);
    idle(3);

    @(negedge clk);
    #1;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
